// File: rtl/dot_accel_pkg.sv
// Shared types and helpers for the dot-product engine: CSR map, FSM states,
// configuration record and the Q16.16 multiply-truncate.
package dot_accel_pkg;
  localparam int QW   = 32;
  localparam int FRAC = 16;

  localparam logic [2:0] CSR_CTRL  = 3'd0;
  localparam logic [2:0] CSR_WBASE = 3'd1;
  localparam logic [2:0] CSR_ABASE = 3'd2;
  localparam logic [2:0] CSR_LEN   = 3'd3;
  localparam logic [2:0] CSR_CFG   = 3'd4;
  localparam logic [2:0] CSR_STAT  = 3'd5;

  typedef enum logic [2:0] {
    IDLE, REQ_W, WAIT_W, REQ_A, WAIT_A, MAC, FINISH, DONE
  } state_t;

  typedef struct packed {
    logic [31:0] w_base;
    logic [31:0] a_base;
    logic [31:0] len;
    logic        relu_en;
  } cfg_t;

  // Full 64-bit signed product, keep the Q16.16 window.
  function automatic logic [QW-1:0] q_mul(input logic [QW-1:0] w, input logic [QW-1:0] a);
    logic signed [2*QW-1:0] p;
    p = $signed({{QW{w[QW-1]}}, w}) * $signed({{QW{a[QW-1]}}, a});
    return p[FRAC+QW-1:FRAC];
  endfunction
endpackage

// File: rtl/dot_accel_mac.sv
// Registered multiply-accumulate; the sum wraps in 32-bit two's complement.
module dot_accel_mac
  import dot_accel_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  input  logic [QW-1:0] w,
  input  logic [QW-1:0] a,
  output logic [QW-1:0] acc
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   acc <= '0;
    else if (clr) acc <= '0;
    else if (en)  acc <= acc + q_mul(w, a);
  end
endmodule

// File: rtl/dot_accel.sv
// Dot-product engine: CSR slave, single-outstanding read master fetching
// w[i] then a[i], MAC per element, optional ReLU on the final sum.
module dot_accel
  import dot_accel_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 32
) (
  input  logic          clk_clk,
  input  logic          reset_reset_n,
  input  logic [2:0]    slave_address,
  input  logic          slave_read,
  input  logic          slave_write,
  input  logic [31:0]   slave_writedata,
  output logic [31:0]   slave_readdata,
  output logic          slave_waitrequest,
  output logic [AW-1:0] master_address,
  output logic          master_read,
  input  logic [DW-1:0] master_readdata,
  input  logic          master_waitrequest,
  input  logic          master_readdatavalid
);
  state_t        state;
  cfg_t          cfg;
  logic [31:0]   idx;
  logic [DW-1:0] w_q, a_q;
  logic [31:0]   result;
  logic [QW-1:0] acc;
  logic          busy, cfg_wr, start;

  assign busy   = !(state == IDLE || state == DONE);
  assign cfg_wr = slave_write && !busy;
  assign start  = cfg_wr && (slave_address == CSR_CTRL);

  // Only a result read stalls, and only until DONE exposes the new result.
  assign slave_waitrequest = slave_read && (slave_address == CSR_CTRL) && busy;

  always_comb begin
    slave_readdata = '0;
    if (slave_read) begin
      case (slave_address)
        CSR_CTRL:  slave_readdata = result;
        CSR_WBASE: slave_readdata = cfg.w_base;
        CSR_ABASE: slave_readdata = cfg.a_base;
        CSR_LEN:   slave_readdata = cfg.len;
        CSR_CFG:   slave_readdata = {31'b0, cfg.relu_en};
        CSR_STAT:  slave_readdata = {31'b0, busy};
        default:   slave_readdata = '0;
      endcase
    end
  end

  dot_accel_mac u_mac (
    .clk   (clk_clk),
    .rst_n (reset_reset_n),
    .clr   (start),
    .en    (state == MAC),
    .w     (w_q),
    .a     (a_q),
    .acc   (acc)
  );

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state          <= IDLE;
      cfg            <= '0;
      idx            <= '0;
      w_q            <= '0;
      a_q            <= '0;
      result         <= '0;
      master_read    <= 1'b0;
      master_address <= '0;
    end else begin
      if (cfg_wr) begin
        case (slave_address)
          CSR_WBASE: cfg.w_base  <= slave_writedata;
          CSR_ABASE: cfg.a_base  <= slave_writedata;
          CSR_LEN:   cfg.len     <= slave_writedata;
          CSR_CFG:   cfg.relu_en <= slave_writedata[0];
          default: ;
        endcase
      end
      case (state)
        IDLE, DONE: if (start) begin
          idx <= '0;
          if (cfg.len == 32'd0) state <= FINISH;
          else begin
            state          <= REQ_W;
            master_read    <= 1'b1;
            master_address <= AW'(cfg.w_base);
          end
        end
        REQ_W: if (!master_waitrequest) begin
          master_read <= 1'b0;
          state       <= WAIT_W;
        end
        WAIT_W: if (master_readdatavalid) begin
          w_q            <= master_readdata;
          state          <= REQ_A;
          master_read    <= 1'b1;
          master_address <= AW'(cfg.a_base + (idx << 2));
        end
        REQ_A: if (!master_waitrequest) begin
          master_read <= 1'b0;
          state       <= WAIT_A;
        end
        WAIT_A: if (master_readdatavalid) begin
          a_q   <= master_readdata;
          state <= MAC;
        end
        MAC: begin
          idx <= idx + 32'd1;
          if (idx == cfg.len - 32'd1) state <= FINISH;
          else begin
            state          <= REQ_W;
            master_read    <= 1'b1;
            master_address <= AW'(cfg.w_base + ((idx + 32'd1) << 2));
          end
        end
        FINISH: begin
          result <= (cfg.relu_en && acc[QW-1]) ? 32'd0 : acc;
          state  <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dot_accel.sv
// Randomized scoreboard bench for dot_accel: a memory responder with random
// stalls/latency, a reference dot product, and a monitor on result reads.
module tb_dot_accel;
  logic        clk_clk = 1'b0;
  logic        reset_reset_n = 1'b0;
  logic [2:0]  slave_address = '0;
  logic        slave_read = 1'b0, slave_write = 1'b0;
  logic [31:0] slave_writedata = '0;
  logic [31:0] slave_readdata;
  logic        slave_waitrequest;
  logic [31:0] master_address;
  logic        master_read;
  logic [31:0] master_readdata = '0;
  logic        master_waitrequest = 1'b0, master_readdatavalid = 1'b0;

  dot_accel dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .slave_address(slave_address), .slave_read(slave_read), .slave_write(slave_write),
    .slave_writedata(slave_writedata), .slave_readdata(slave_readdata),
    .slave_waitrequest(slave_waitrequest),
    .master_address(master_address), .master_read(master_read),
    .master_readdata(master_readdata), .master_waitrequest(master_waitrequest),
    .master_readdatavalid(master_readdatavalid)
  );

  always #5 clk_clk = ~clk_clk;

  int          n_cmp = 0, n_bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mem[logic [31:0]];
  logic [31:0] wv[16], av[16];
  bit          rand_mode = 1'b0;
  int          lat_min = 1, lat_max = 1;
  int          acc_cnt = 0, pend = 0;
  logic [31:0] pend_data = '0;
  bit          stalled = 1'b0;
  logic [31:0] stall_addr = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: plain sum of Q16.16 products with 32-bit wrap, then ReLU.
  function automatic logic [31:0] model(input int n, input bit relu);
    int acc = 0;
    longint p;
    for (int i = 0; i < n; i++) begin
      p = longint'($signed(wv[i])) * longint'($signed(av[i]));
      acc += int'(p >>> 16);
    end
    if (relu && acc < 0) acc = 0;
    return 32'(acc);
  endfunction

  // Memory responder: inputs change on negedge; acceptance is decided for the next posedge.
  initial forever begin
    @(negedge clk_clk);
    master_readdatavalid = 1'b0;
    if (stalled && reset_reset_n) begin
      chk("stall_read", 32'(master_read), 32'd1);
      chk("stall_addr", master_address, stall_addr);
    end
    stalled = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        master_readdatavalid = 1'b1;
        master_readdata = pend_data;
      end
    end
    master_waitrequest = rand_mode ? ($urandom_range(0, 1) == 1) : 1'b0;
    if (master_read && reset_reset_n) begin
      if (master_waitrequest) begin
        stalled = 1'b1;
        stall_addr = master_address;
      end else begin
        acc_cnt++;
        pend = int'($urandom_range(lat_min, lat_max));
        pend_data = mem.exists(master_address) ? mem[master_address] : 32'h0;
      end
    end
  end

  // Monitor: every completed result read is checked against the scoreboard.
  initial forever begin
    @(negedge clk_clk);
    if (reset_reset_n && slave_read && slave_address == 3'd0 && !slave_waitrequest) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL result_unexpected: got %h expected no read", slave_readdata);
      end else chk("result", slave_readdata, exp_q.pop_front());
    end
  end

  task automatic csr_write(input logic [2:0] ad, input logic [31:0] v);
    @(posedge clk_clk); #1;
    slave_address = ad; slave_writedata = v; slave_write = 1'b1;
    @(negedge clk_clk);
    chk("write_nowait", 32'(slave_waitrequest), 32'd0);
    @(posedge clk_clk); #1;
    slave_write = 1'b0;
  endtask

  task automatic csr_read(input logic [2:0] ad, output logic [31:0] d, output int cyc);
    @(posedge clk_clk); #1;
    slave_address = ad; slave_read = 1'b1; cyc = -1; d = 'x;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_clk);
      if (!slave_waitrequest) begin d = slave_readdata; cyc = i + 1; break; end
    end
    if (cyc < 0) begin
      n_cmp++; n_bad++;
      $display("FAIL read_timeout: addr %0d still stalled, required completion", ad);
      if (ad == 3'd0 && exp_q.size() > 0) void'(exp_q.pop_front());
    end
    @(posedge clk_clk); #1;
    slave_read = 1'b0;
  endtask

  task automatic setup_job(input logic [31:0] wb, input logic [31:0] ab, input int n, input bit relu);
    for (int i = 0; i < n; i++) begin
      mem[32'(wb + 32'(4 * i))] = wv[i];
      mem[32'(ab + 32'(4 * i))] = av[i];
    end
    csr_write(3'd1, wb); csr_write(3'd2, ab);
    csr_write(3'd3, 32'(n)); csr_write(3'd4, {31'b0, relu});
    exp_q.push_back(model(n, relu));
  endtask

  task automatic run_job(input logic [31:0] wb, input logic [31:0] ab, input int n, input bit relu);
    logic [31:0] d; int cyc;
    setup_job(wb, ab, n, relu);
    csr_write(3'd0, 32'd1);
    csr_read(3'd0, d, cyc);
  endtask

  initial begin
    logic [31:0] d; int cyc, base;
    // reset state
    #1;
    chk("rst_master_read", 32'(master_read), 32'd0);
    chk("rst_master_addr", master_address, 32'd0);
    chk("rst_waitreq", 32'(slave_waitrequest), 32'd0);
    chk("rst_readdata", slave_readdata, 32'd0);
    repeat (3) @(posedge clk_clk);
    #1 reset_reset_n = 1'b1;
    exp_q.push_back(32'd0);
    csr_read(3'd0, d, cyc);
    csr_read(3'd5, d, cyc); chk("idle_status", d, 32'd0);
    csr_write(3'd6, 32'hDEAD_BEEF);
    csr_read(3'd6, d, cyc); chk("addr6_zero", d, 32'd0);

    // 1.0*3.0 + 2.0*0.25 - 0.5*4.0 = 1.5; busy status, ignored LEN write, stalled read
    wv[0] = 32'h0001_0000; wv[1] = 32'h0002_0000; wv[2] = 32'hFFFF_8000;
    av[0] = 32'h0003_0000; av[1] = 32'h0000_4000; av[2] = 32'h0004_0000;
    setup_job(32'h1000, 32'h2000, 3, 1'b0);
    csr_write(3'd0, 32'd1);
    csr_read(3'd5, d, cyc); chk("busy_status", d, 32'd1);
    csr_write(3'd3, 32'd7);
    csr_read(3'd0, d, cyc); chk("read_stalled", 32'(cyc > 1), 32'd1);
    csr_read(3'd3, d, cyc); chk("len_write_ignored", d, 32'd3);
    csr_read(3'd5, d, cyc); chk("done_status", d, 32'd0);

    // w0=-4.0: sum is -13.5, clamped by ReLU when enabled
    wv[0] = 32'hFFFC_0000;
    run_job(32'h1000, 32'h2000, 3, 1'b1);
    run_job(32'h1000, 32'h2000, 3, 1'b0);

    // LEN=0: immediate zero result, no memory traffic
    base = acc_cnt;
    setup_job(32'h1000, 32'h2000, 0, 1'b0);
    csr_write(3'd0, 32'd1);
    csr_read(3'd0, d, cyc);
    chk("len0_latency_ok", 32'(cyc >= 1 && cyc <= 3), 32'd1);
    chk("len0_no_reads", 32'(acc_cnt), 32'(base));

    // overflow wrap
    wv[0] = 32'h7FFF_0000; wv[1] = 32'h7FFF_0000;
    av[0] = 32'h7FFF_0000; av[1] = 32'h7FFF_0000;
    run_job(32'h3000, 32'h4000, 2, 1'b0);
    chk("no_x", 32'($isunknown({master_address, master_read, slave_waitrequest, slave_readdata})), 32'd0);

    // random stalls and latency
    rand_mode = 1'b1; lat_min = 1; lat_max = 8;
    for (int j = 0; j < 4; j++) begin
      for (int i = 0; i < 16; i++) begin wv[i] = $urandom; av[i] = $urandom; end
      base = int'($urandom_range(0, 32'h00FF_0000)) * 4;
      run_job(32'(base), 32'(base + 32'h100), 16, 1'($urandom_range(0, 1)));
    end
    // address wrap past 2^32
    run_job(32'hFFFF_FFF8, 32'h0000_0100, 4, 1'b0);
    rand_mode = 1'b0;

    // reset during WAIT_A of element 0, then a clean rerun
    lat_min = 4; lat_max = 4;
    for (int i = 0; i < 8; i++) begin wv[i] = $urandom; av[i] = $urandom; end
    setup_job(32'h5000, 32'h6000, 8, 1'b0);
    base = acc_cnt;
    csr_write(3'd0, 32'd1);
    cyc = -1;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk_clk);
      if (acc_cnt >= base + 2) begin cyc = i; break; end
    end
    if (cyc < 0) begin n_cmp++; n_bad++; $display("FAIL wait_a_timeout: got no A read, required one"); end
    #1 slave_address = 3'd2; slave_read = 1'b1;
    reset_reset_n = 1'b0;
    #1;
    chk("midrst_master_read", 32'(master_read), 32'd0);
    chk("midrst_master_addr", master_address, 32'd0);
    chk("midrst_waitreq", 32'(slave_waitrequest), 32'd0);
    chk("midrst_readdata", slave_readdata, 32'd0);
    void'(exp_q.pop_front());
    slave_read = 1'b0;
    @(posedge clk_clk); #1 reset_reset_n = 1'b1;
    repeat (10) @(posedge clk_clk);
    csr_read(3'd5, d, cyc); chk("midrst_status", d, 32'd0);
    exp_q.push_back(32'd0);
    csr_read(3'd0, d, cyc);
    lat_min = 1; lat_max = 1;
    run_job(32'h5000, 32'h6000, 8, 1'b0);

    repeat (5) @(posedge clk_clk);
    if (exp_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard_leftover: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end
endmodule
